// File: rtl/gcd_feeder.sv
// Operand FIFO and sequencer in front of gcd_core: issues load/A/B, waits for done with a
// watchdog, bypasses pairs that contain a zero, and returns results on a valid/ready port.
module gcd_feeder #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         busy,
  output logic         core_load,
  output logic [W-1:0] core_din,
  input  logic [W-1:0] core_gcd_rslt,
  input  logic         core_done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] Full   = CntW'(DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StOpa    = 3'd2;
  localparam logic [2:0] StOpb    = 3'd3;
  localparam logic [2:0] StWait   = 3'd4;
  localparam logic [2:0] StResult = 3'd5;

  logic [2*W-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;
  logic [W-1:0]    rd_a, rd_b;

  logic [2:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic            err_q, err_d;
  logic [WdW-1:0]  wd_q, wd_d;

  // in_ready depends only on the registered count, never on this cycle's pop.
  assign in_ready = (count_q != Full);
  assign push     = in_valid && in_ready;
  assign rd_a     = mem_q[rd_ptr_q][2*W-1:W];
  assign rd_b     = mem_q[rd_ptr_q][W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    wd_d    = wd_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop = 1'b1;
          a_d = rd_a;
          b_d = rd_b;
          if (rd_a == '0 || rd_b == '0) begin
            gcd_d   = rd_a | rd_b;
            err_d   = 1'b0;
            state_d = StResult;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: state_d = StOpa;
      StOpa:  state_d = StOpb;
      StOpb: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (core_done) begin
          gcd_d   = core_gcd_rslt;
          err_d   = 1'b0;
          state_d = StResult;
        end else begin
          wd_d = wd_q + WdW'(1);
          if (wd_q == WdLast) begin
            gcd_d   = '0;
            err_d   = 1'b1;
            state_d = StResult;
          end
        end
      end
      StResult: begin
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign out_valid = (state_q == StResult);
  assign out_gcd   = gcd_q;
  assign out_err   = err_q;
  assign busy      = (state_q != StIdle) || (count_q != '0);
  // Gated by rst so a reset landing on the LOAD cycle never pulses the core.
  assign core_load = (state_q == StLoad) && !rst;

  always_comb begin
    core_din = '0;
    if (state_q == StOpa) core_din = a_q;
    if (state_q == StOpb) core_din = b_q;
  end

endmodule
